// File: rtl/frame_capture_pkg.sv
// Purpose: shared state encoding, frame geometry defaults and RGB332 layout for frame_capture_ctrl.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frame_capture_pkg;

  localparam int H_ACTIVE_DFLT     = 640;
  localparam int V_ACTIVE_DFLT     = 480;
  localparam int FRAME_PIXELS_DFLT = H_ACTIVE_DFLT * V_ACTIVE_DFLT;
  localparam int ADDR_W_DFLT       = $clog2(FRAME_PIXELS_DFLT);

  // RGB332 pixel layout: RRRGGGBB
  localparam int RGB332_R_MSB = 7;
  localparam int RGB332_R_LSB = 5;
  localparam int RGB332_G_MSB = 4;
  localparam int RGB332_G_LSB = 2;
  localparam int RGB332_B_MSB = 1;
  localparam int RGB332_B_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SKIP,
    ST_WAIT_FS,
    ST_CAPTURE,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_SEND,
    ST_FIN
  } state_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/frame_capture_ctrl_tx_holdoff.sv
// Purpose: UART idle-holdoff counter; ready_o once the line has been idle 2^W-1 cycles.
// Latency: ready_o is registered state, cleared the edge after tx_busy_i is seen high.
// Backpressure: tx_busy_i clears the count; the counter saturates at all-ones while idle.
// Ports: clk, rst (sync, active-high), tx_busy_i (UART data_wait), ready_o (holdoff satisfied).
module tx_holdoff #(
  parameter int W = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_busy_i,
  output logic ready_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || tx_busy_i) begin
      cnt_q <= '0;
    end else if (!ready_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ready_o = &cnt_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Purpose: owns the shared pixel buffer: arm, skip settle frames, capture one RGB332 frame, stream it to the UART.
// Latency: buffer write 1 cycle after pix_valid; each byte costs RD_ADDR+RD_WAIT+SEND plus holdoff/busy wait.
// Backpressure: pixels are never stalled (excess dropped, err_overflow); readout stalls in SEND on tx_busy/holdoff.
// Ports: clk/rst; arm/continuous control; frame_start/frame_end/pix_valid/pix_data camera side;
//        buf_addr/buf_we/buf_wdata/buf_rdata buffer side; tx_data/tx_we/tx_busy UART side;
//        busy/done/pix_count/err_short/err_overflow status.
module frame_capture_ctrl
  import frame_capture_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DFLT,
  parameter int V_ACTIVE    = V_ACTIVE_DFLT,
  parameter int ADDR_W      = ADDR_W_DFLT,
  parameter int SKIP_FRAMES = 2,
  parameter int HOLDOFF_W   = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              continuous,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  output logic [ADDR_W-1:0] buf_addr,
  output logic              buf_we,
  output logic [7:0]        buf_wdata,
  input  logic [7:0]        buf_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_we,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pix_count,
  output logic              err_short,
  output logic              err_overflow
);

  // One extra bit so the pointer can reach FRAME_PIXELS itself (the overflow marker).
  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  FP_C      = CNT_W'(H_ACTIVE * V_ACTIVE);
  localparam int                SKIP_W    = cnt_width(SKIP_FRAMES);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

  state_e            state_q;
  logic [SKIP_W-1:0] skip_cnt_q;
  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  pix_cnt_q;
  logic              end_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic              buf_we_q;
  logic [7:0]        buf_wdata_q;
  logic [7:0]        tx_data_q;
  logic              tx_we_q;
  logic              busy_q;
  logic              done_q;
  logic              err_short_q;
  logic              err_overflow_q;
  logic              wr_ok;
  logic              hold_ready;

  tx_holdoff #(
    .W(HOLDOFF_W)
  ) u_holdoff (
    .clk      (clk),
    .rst      (rst),
    .tx_busy_i(tx_busy),
    .ready_o  (hold_ready)
  );

  assign wr_ok    = pix_valid && (wr_ptr_q < FP_C);
  assign wr_ptr_d = wr_ok ? wr_ptr_q + CNT_W'(1) : wr_ptr_q;
  assign rd_ptr_d = rd_ptr_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      skip_cnt_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      pix_cnt_q      <= '0;
      end_q          <= 1'b0;
      buf_addr_q     <= '0;
      buf_we_q       <= 1'b0;
      buf_wdata_q    <= '0;
      tx_data_q      <= '0;
      tx_we_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_short_q    <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      buf_we_q <= 1'b0;
      tx_we_q  <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            busy_q     <= 1'b1;
            skip_cnt_q <= '0;
            state_q    <= (SKIP_FRAMES == 0) ? ST_WAIT_FS : ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (frame_end) begin
            skip_cnt_q <= skip_cnt_q + 1'b1;
            if (skip_cnt_q == SKIP_LAST) state_q <= ST_WAIT_FS;
          end
        end
        ST_WAIT_FS: begin
          if (frame_start) begin
            wr_ptr_q       <= '0;
            err_short_q    <= 1'b0;
            err_overflow_q <= 1'b0;
            state_q        <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (end_q) begin
            // Drain cycle: the final write (if any) is on the bus now, so the
            // buffer is released to readout only after it has landed.
            end_q <= 1'b0;
            if (pix_cnt_q == '0) begin
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end else begin
              rd_ptr_q   <= '0;
              buf_addr_q <= '0;
              state_q    <= ST_RD_ADDR;
            end
          end else if (frame_start && !frame_end) begin
            // frame_end was lost: restart the frame and flag it.
            wr_ptr_q    <= '0;
            err_short_q <= 1'b1;
          end else begin
            if (wr_ok) begin
              buf_we_q    <= 1'b1;
              buf_addr_q  <= wr_ptr_q[ADDR_W-1:0];
              buf_wdata_q <= pix_data;
            end
            if (pix_valid && !wr_ok) err_overflow_q <= 1'b1;
            wr_ptr_q <= wr_ptr_d;
            if (frame_end) begin
              pix_cnt_q <= wr_ptr_d;
              if (wr_ptr_d < FP_C) err_short_q <= 1'b1;
              end_q <= 1'b1;
            end
          end
        end
        ST_RD_ADDR: state_q <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          tx_data_q <= buf_rdata;
          state_q   <= ST_SEND;
        end
        ST_SEND: begin
          if (!tx_busy && hold_ready) begin
            tx_we_q  <= 1'b1;
            rd_ptr_q <= rd_ptr_d;
            if (rd_ptr_q == pix_cnt_q - CNT_W'(1)) begin
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end else begin
              buf_addr_q <= rd_ptr_d[ADDR_W-1:0];
              state_q    <= ST_RD_ADDR;
            end
          end
        end
        ST_FIN: begin
          busy_q  <= continuous;
          state_q <= continuous ? ST_WAIT_FS : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign buf_addr     = buf_addr_q;
  assign buf_we       = buf_we_q;
  assign buf_wdata    = buf_wdata_q;
  assign tx_data      = tx_data_q;
  assign tx_we        = tx_we_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pix_count    = pix_cnt_q[ADDR_W-1:0];
  assign err_short    = err_short_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Purpose: randomized self-checking bench for frame_capture_ctrl with buffer RAM and UART models.
// Latency: n/a.
// Backpressure: UART model holds tx_busy for a programmable time after every byte.
module tb_frame_capture_ctrl;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int AW   = 6;
  localparam int SKIP = 2;
  localparam int HW   = 4;
  localparam int FP   = H * V;
  localparam int GAP  = (1 << HW) - 1;

  logic          clk = 1'b0;
  logic          rst, arm, continuous, frame_start, frame_end, pix_valid;
  logic [7:0]    pix_data, buf_wdata, buf_rdata, tx_data;
  logic [AW-1:0] buf_addr, pix_count;
  logic          buf_we, tx_we, tx_busy, busy, done, err_short, err_overflow;

  always #5 clk = ~clk;

  frame_capture_ctrl #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .SKIP_FRAMES(SKIP), .HOLDOFF_W(HW)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .continuous(continuous),
    .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .tx_data(tx_data), .tx_we(tx_we), .tx_busy(tx_busy),
    .busy(busy), .done(done), .pix_count(pix_count),
    .err_short(err_short), .err_overflow(err_overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Buffer RAM, UART and observation model, all evaluated on the falling edge.
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] rd_pipe;
  int wr_addr_q[$];
  int wr_dat_q[$];
  int tx_q[$];
  int done_cnt, busy_len, busy_cnt, cyc, fall_cyc;
  bit fall_seen;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    rd_pipe = 8'h00; buf_rdata = 8'h00; tx_busy = 1'b0;
    done_cnt = 0; busy_len = 0; busy_cnt = 0; cyc = 0; fall_cyc = 0; fall_seen = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (buf_we === 1'b1) begin
        mem[buf_addr] = buf_wdata;
        wr_addr_q.push_back(int'(buf_addr));
        wr_dat_q.push_back(int'(buf_wdata));
      end
      // Synchronous read: data for the address seen this cycle appears next cycle.
      buf_rdata = rd_pipe;
      rd_pipe   = mem[buf_addr];
      if (tx_we === 1'b1) begin
        if (fall_seen) chk("holdoff_gap", 32'((cyc - fall_cyc) >= GAP), 32'd1);
        fall_seen = 0;
        tx_q.push_back(int'(tx_data));
        busy_cnt = busy_len;
      end
      if (done === 1'b1) done_cnt++;
      if (busy_cnt > 0) begin
        tx_busy = 1'b1;
        busy_cnt--;
      end else begin
        if (tx_busy) begin
          fall_seen = 1;
          fall_cyc  = cyc;
        end
        tx_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input bit coinc);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      pix_valid = 1'b1;
      pix_data  = 8'(int'(base) + i);
      if (coinc && i == n - 1) frame_end = 1'b1;
      tick();
      pix_valid = 1'b0; frame_end = 1'b0;
    end
    if (!(coinc && n > 0)) begin
      frame_end = 1'b1; tick(); frame_end = 1'b0;
    end
    repeat (3) tick();
  endtask

  // Reference: the first min(n,FP) pixels are stored at 0.. and sent back in order.
  task automatic run_capture(input string tag, input int n, input logic [7:0] base,
                             input bit coinc, input bit do_arm, input bit do_skip,
                             input bit clear_cont, input int blen);
    int nw, t;
    busy_len = blen;
    wr_addr_q.delete(); wr_dat_q.delete(); tx_q.delete(); done_cnt = 0;
    if (do_arm) begin arm = 1'b1; tick(); arm = 1'b0; end
    if (do_skip)
      for (int f = 0; f < SKIP; f++) send_frame($urandom_range(1, FP), 8'($urandom), 1'b0);
    send_frame(n, base, coinc);
    if (n > 0) begin arm = 1'b1; tick(); arm = 1'b0; end
    if (clear_cont) continuous = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 20000) begin @(negedge clk); t++; end
    chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (4) tick();
    nw = (n < FP) ? n : FP;
    chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    chk({tag, "_n_writes"}, 32'(wr_addr_q.size()), 32'(nw));
    for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
      chk({tag, "_wr_addr"}, 32'(wr_addr_q[i]), 32'(i));
      chk({tag, "_wr_data"}, 32'(wr_dat_q[i]), 32'((int'(base) + i) & 255));
    end
    chk({tag, "_n_bytes"}, 32'(tx_q.size()), 32'(nw));
    for (int i = 0; i < nw && i < tx_q.size(); i++)
      chk({tag, "_tx_byte"}, 32'(tx_q[i]), 32'((int'(base) + i) & 255));
    chk({tag, "_pix_count"}, 32'(pix_count), 32'(nw));
    chk({tag, "_err_short"}, 32'(err_short), 32'(nw < FP));
    chk({tag, "_err_overflow"}, 32'(err_overflow), 32'(n > FP));
    chk({tag, "_busy_after"}, 32'(busy), 32'(continuous));
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; continuous = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    pix_valid = 1'b0; pix_data = 8'h00;
    repeat (3) tick();
    chk("rst_buf_we", 32'(buf_we), 32'd0);
    chk("rst_tx_we", 32'(tx_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pix_count", 32'(pix_count), 32'd0);
    chk("rst_errs", 32'({err_short, err_overflow}), 32'd0);
    rst = 1'b0;
    tick();

    run_capture("basic", FP, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, $urandom_range(1, 20));
    run_capture("short", 20, 8'($urandom), 1'b0, 1'b1, 1'b1, 1'b0, $urandom_range(1, 20));
    run_capture("ovf", 40, 8'($urandom), 1'b0, 1'b1, 1'b1, 1'b0, $urandom_range(1, 20));
    run_capture("hold", FP, 8'($urandom), 1'b0, 1'b1, 1'b1, 1'b0, 100);
    run_capture("empty", 0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 5);

    // Reset in the middle of a capture, then a clean full capture from address 0.
    busy_len = 5;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int f = 0; f < SKIP; f++) send_frame($urandom_range(1, FP), 8'($urandom), 1'b0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pix_valid = 1'b1; pix_data = 8'(i); tick(); pix_valid = 1'b0;
    end
    pix_valid = 1'b1; pix_data = 8'd10; rst = 1'b1;
    tick();
    pix_valid = 1'b0; rst = 1'b0;
    chk("midrst_buf_we", 32'(buf_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pix_count", 32'(pix_count), 32'd0);
    tick();
    run_capture("after_rst", FP, 8'($urandom), 1'b0, 1'b1, 1'b1, 1'b0, $urandom_range(1, 20));

    // Continuous mode: second frame starts without arm; last pixel rides on frame_end.
    continuous = 1'b1;
    run_capture("cont_a", FP, 8'($urandom), 1'b1, 1'b1, 1'b1, 1'b0, $urandom_range(1, 20));
    run_capture("cont_b", $urandom_range(1, FP), 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b1,
                $urandom_range(1, 20));

    for (int k = 0; k < 3; k++)
      run_capture("rand", $urandom_range(0, 40), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'b1, 1'b1, 1'b0, $urandom_range(1, 30));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
